// File: rtl/fpga_harness_pkg.sv
// Shared definitions for the FPGA UART harness.
//   Opcodes live in bits [7:6] of a command byte.
//   lanes(w) gives the number of 8-bit lanes needed to carry a w-bit field.
//   State enums for the command parser, the UART transmitter and the UART receiver.
package fpga_harness_pkg;

   localparam logic [1:0] OP_SET_IN  = 2'b00;
   localparam logic [1:0] OP_SET_SEL = 2'b01;
   localparam logic [1:0] OP_READ    = 2'b10;
   localparam logic [1:0] OP_STATUS  = 2'b11;

   function automatic int lanes(input int w);
      return (w + 7) / 8;
   endfunction

   typedef enum logic [1:0] {P_IDLE, P_WAIT_IN, P_WAIT_SEL} parse_state_t;
   typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

endpackage

// File: rtl/fpga_uart_harness_uart_rx.sv
// UART 8N1 receiver.
//   clk, rst_n : clock, synchronous active-low reset
//   rx         : asynchronous serial input, idle high
//   rx_data    : last received byte (valid while rx_vld is high)
//   rx_vld     : 1-cycle strobe, byte received with a good stop bit
//   rx_ferr    : 1-cycle strobe, stop bit sampled low (byte discarded)
module uart_rx
   import fpga_harness_pkg::*;
#(
   parameter int DIV = 104
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       rx,
   output logic [7:0] rx_data,
   output logic       rx_vld,
   output logic       rx_ferr
);

   localparam int CW = $clog2(DIV + 1);
   localparam logic [CW-1:0] FULL_M1 = CW'(DIV - 1);
   localparam logic [CW-1:0] HALF_M1 = CW'(DIV / 2 - 1);

   rx_state_t     state, state_nx;
   logic          rx_s1, rx_s2, rx_s3;
   logic [CW-1:0] cnt;
   logic [2:0]    bit_idx;
   logic [7:0]    shreg;
   logic          fall, half_tick, full_tick;

   // rx_s3 only exists to see a falling edge on the synchronised line
   assign fall      = rx_s3 & ~rx_s2;
   assign half_tick = (cnt == HALF_M1);
   assign full_tick = (cnt == FULL_M1);
   assign rx_data   = shreg;

   always_comb begin
      state_nx = state;
      case (state)
         RX_IDLE:  if (fall) state_nx = RX_START;
         // a start bit that is high again at mid-bit was a glitch
         RX_START: if (half_tick) state_nx = rx_s2 ? RX_IDLE : RX_DATA;
         RX_DATA:  if (full_tick && bit_idx == 3'd7) state_nx = RX_STOP;
         RX_STOP:  if (full_tick) state_nx = RX_IDLE;
         default:  state_nx = RX_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state   <= RX_IDLE;
         rx_s1   <= 1'b1;
         rx_s2   <= 1'b1;
         rx_s3   <= 1'b1;
         cnt     <= '0;
         bit_idx <= '0;
         rx_vld  <= 1'b0;
         rx_ferr <= 1'b0;
      end else begin
         rx_s1   <= rx;
         rx_s2   <= rx_s1;
         rx_s3   <= rx_s2;
         state   <= state_nx;
         rx_vld  <= 1'b0;
         rx_ferr <= 1'b0;
         case (state)
            RX_IDLE: begin
               cnt     <= '0;
               bit_idx <= '0;
            end
            // counter restarts at mid-start so later samples land mid-bit
            RX_START: cnt <= half_tick ? '0 : cnt + 1'b1;
            RX_DATA: begin
               if (full_tick) begin
                  cnt     <= '0;
                  bit_idx <= bit_idx + 1'b1;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            RX_STOP: begin
               if (full_tick) begin
                  cnt     <= '0;
                  rx_vld  <= rx_s2;
                  rx_ferr <= ~rx_s2;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: cnt <= '0;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (state == RX_DATA && full_tick) shreg <= {rx_s2, shreg[7:1]};
   end

endmodule

// File: rtl/fpga_uart_harness.sv
// Host-UART controlled harness front end.
//   CLK, RESET_N : clock, synchronous active-low reset
//   RX, TX       : host UART, 8N1
//   RTS          : host clear-to-send, active low (gates TX frame starts when USE_RTS=1)
//   PRJ_OUT      : project outputs, returned by READ
//   PRJ_READY    : harness ready flag, returned by STATUS
//   PRJ_IN       : project inputs, written lane by lane by SET_IN
//   PRJ_SEL      : project index, written by SET_SEL
//   ERR_LED      : sticky framing-error / response-overflow flag
//   ACT_LED      : toggles on each completed command
module fpga_uart_harness
   import fpga_harness_pkg::*;
#(
   parameter int CLK_HZ    = 12_000_000,
   parameter int BAUD      = 115_200,
   parameter int IN_W      = 8,
   parameter int OUT_W     = 8,
   parameter int SEL_W     = 9,
   parameter int TXQ_DEPTH = 8,
   parameter int USE_RTS   = 1
) (
   input  logic             CLK,
   input  logic             RESET_N,
   input  logic             RX,
   input  logic             RTS,
   input  logic [OUT_W-1:0] PRJ_OUT,
   input  logic             PRJ_READY,
   output logic [IN_W-1:0]  PRJ_IN,
   output logic [SEL_W-1:0] PRJ_SEL,
   output logic             TX,
   output logic             ERR_LED,
   output logic             ACT_LED
);

   localparam int DIV = (CLK_HZ + BAUD / 2) / BAUD;
   localparam int NLI = lanes(IN_W);
   localparam int NLO = lanes(OUT_W);
   localparam int PW  = 8 * NLO;
   localparam int AW  = $clog2(TXQ_DEPTH);
   localparam int CW  = $clog2(DIV + 1);

   if (DIV < 4) begin : g_div_check
      $error("fpga_uart_harness: DIV=%0d must be at least 4", DIV);
   end
   if (TXQ_DEPTH < NLO) begin : g_depth_check
      $error("fpga_uart_harness: TXQ_DEPTH must hold a full READ response");
   end

   logic [7:0] rx_data;
   logic       rx_vld, rx_ferr;

   uart_rx #(.DIV(DIV)) u_rx (
      .clk     (CLK),
      .rst_n   (RESET_N),
      .rx      (RX),
      .rx_data (rx_data),
      .rx_vld  (rx_vld),
      .rx_ferr (rx_ferr)
   );

   parse_state_t  p_state, p_nx;
   logic [5:0]    lane_q, hi_q;
   logic          ld_lane, ld_hi, do_in, do_sel, done;
   logic [AW+1:0] req_len, free_slots, push_len;
   logic          overflow;
   logic [7:0]    resp [NLO];
   logic [PW-1:0] out_pad;

   logic [7:0]    mem [TXQ_DEPTH];
   logic [AW:0]   wr_ptr, rd_ptr, fill;
   logic          empty, pop, start_ok;

   tx_state_t     t_state, t_nx;
   logic [CW-1:0] t_cnt;
   logic [2:0]    t_bit;
   logic [7:0]    t_sh;
   logic          t_full;

   assign out_pad = PW'(PRJ_OUT);
   assign fill    = wr_ptr - rd_ptr;
   assign empty   = (wr_ptr == rd_ptr);

   // Response bytes; only meaningful in the cycle a READ/STATUS opcode is accepted
   always_comb begin
      for (int i = 0; i < NLO; i++) resp[i] = out_pad[8*i +: 8];
      if (rx_data[7:6] == OP_STATUS) resp[0] = {PRJ_READY, RTS, ERR_LED, 5'b0};
   end

   always_comb begin
      p_nx    = p_state;
      req_len = '0;
      ld_lane = 1'b0;
      ld_hi   = 1'b0;
      do_in   = 1'b0;
      do_sel  = 1'b0;
      done    = 1'b0;
      if (rx_ferr) begin
         p_nx = P_IDLE;
      end else if (rx_vld) begin
         case (p_state)
            P_IDLE: begin
               case (rx_data[7:6])
                  OP_SET_IN: begin
                     ld_lane = 1'b1;
                     p_nx    = P_WAIT_IN;
                  end
                  OP_SET_SEL: begin
                     ld_hi = 1'b1;
                     p_nx  = P_WAIT_SEL;
                  end
                  OP_READ: begin
                     req_len = (AW+2)'(NLO);
                     done    = 1'b1;
                  end
                  default: begin
                     req_len = (AW+2)'(1);
                     done    = 1'b1;
                  end
               endcase
            end
            P_WAIT_IN: begin
               do_in = 1'b1;
               done  = 1'b1;
               p_nx  = P_IDLE;
            end
            P_WAIT_SEL: begin
               do_sel = 1'b1;
               done   = 1'b1;
               p_nx   = P_IDLE;
            end
            default: p_nx = P_IDLE;
         endcase
      end
   end

   // A slot being popped this cycle is free for this cycle's push
   always_comb begin
      free_slots = (AW+2)'(TXQ_DEPTH) - {1'b0, fill} + {{(AW+1){1'b0}}, pop};
      overflow   = (req_len != '0) && (req_len > free_slots);
      push_len   = overflow ? '0 : req_len;
   end

   always_ff @(posedge CLK) begin
      if (!RESET_N) begin
         p_state <= P_IDLE;
         PRJ_IN  <= '0;
         PRJ_SEL <= '0;
         ERR_LED <= 1'b0;
         ACT_LED <= 1'b0;
      end else begin
         p_state <= p_nx;
         // lanes beyond the port width never match, so their data byte is dropped
         if (do_in) begin
            for (int b = 0; b < IN_W; b++) begin
               if (int'(lane_q) == b / 8) PRJ_IN[b] <= rx_data[b % 8];
            end
         end
         if (do_sel) PRJ_SEL <= SEL_W'({hi_q, rx_data});
         if (rx_ferr || overflow) ERR_LED <= 1'b1;
         if (done) ACT_LED <= ~ACT_LED;
      end
   end

   always_ff @(posedge CLK) begin
      if (ld_lane) lane_q <= rx_data[5:0];
      if (ld_hi)   hi_q   <= rx_data[5:0];
   end

   always_ff @(posedge CLK) begin
      if (!RESET_N) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         wr_ptr <= wr_ptr + push_len[AW:0];
         rd_ptr <= rd_ptr + {{AW{1'b0}}, pop};
      end
   end

   always_ff @(posedge CLK) begin
      for (int i = 0; i < NLO; i++) begin
         if ((AW+2)'(i) < push_len) mem[wr_ptr[AW-1:0] + AW'(i)] <= resp[i];
      end
   end

   assign start_ok = !empty && ((USE_RTS == 0) || !RTS);
   assign pop      = (t_state == TX_IDLE) && start_ok;
   assign t_full   = (t_cnt == CW'(DIV - 1));

   always_comb begin
      t_nx = t_state;
      case (t_state)
         TX_IDLE:  if (pop) t_nx = TX_START;
         TX_START: if (t_full) t_nx = TX_DATA;
         TX_DATA:  if (t_full && t_bit == 3'd7) t_nx = TX_STOP;
         TX_STOP:  if (t_full) t_nx = TX_IDLE;
         default:  t_nx = TX_IDLE;
      endcase
   end

   // TX is registered; each level is set on the edge that enters its bit period
   always_ff @(posedge CLK) begin
      if (!RESET_N) begin
         t_state <= TX_IDLE;
         t_cnt   <= '0;
         t_bit   <= '0;
         TX      <= 1'b1;
      end else begin
         t_state <= t_nx;
         case (t_state)
            TX_IDLE: begin
               t_cnt <= '0;
               t_bit <= '0;
               if (pop) TX <= 1'b0;
            end
            TX_START: begin
               if (t_full) begin
                  t_cnt <= '0;
                  TX    <= t_sh[0];
               end else begin
                  t_cnt <= t_cnt + 1'b1;
               end
            end
            TX_DATA: begin
               if (t_full) begin
                  t_cnt <= '0;
                  t_bit <= t_bit + 1'b1;
                  // t_sh[1] is the next bit because the shift happens on this same edge
                  TX    <= (t_bit == 3'd7) ? 1'b1 : t_sh[1];
               end else begin
                  t_cnt <= t_cnt + 1'b1;
               end
            end
            TX_STOP: t_cnt <= t_full ? '0 : t_cnt + 1'b1;
            default: TX <= 1'b1;
         endcase
      end
   end

   always_ff @(posedge CLK) begin
      if (pop) t_sh <= mem[rd_ptr[AW-1:0]];
      else if (t_state == TX_DATA && t_full) t_sh <= t_sh >> 1;
   end

endmodule

// File: tb/tb_fpga_uart_harness.sv
// Scoreboard bench for fpga_uart_harness (DIV=10, 16-bit in/out, 9-bit select, 4-deep TX queue).
// Commands are sent as host UART frames; a reference model predicts register outputs and
// queues expected response bytes, and a separate TX monitor decodes frames and pops/compares.
module tb_fpga_uart_harness;

   localparam int DIV = 10;

   logic        CLK = 1'b0;
   logic        RESET_N = 1'b0;
   logic        RX = 1'b1;
   logic        RTS = 1'b0;
   logic [15:0] PRJ_OUT = '0;
   logic        PRJ_READY = 1'b0;
   logic [15:0] PRJ_IN;
   logic [8:0]  PRJ_SEL;
   logic        TX, ERR_LED, ACT_LED;

   always #5 CLK = ~CLK;

   fpga_uart_harness #(
      .CLK_HZ(1_000_000), .BAUD(100_000), .IN_W(16), .OUT_W(16),
      .SEL_W(9), .TXQ_DEPTH(4), .USE_RTS(1)
   ) dut (
      .CLK(CLK), .RESET_N(RESET_N), .RX(RX), .RTS(RTS), .PRJ_OUT(PRJ_OUT),
      .PRJ_READY(PRJ_READY), .PRJ_IN(PRJ_IN), .PRJ_SEL(PRJ_SEL), .TX(TX),
      .ERR_LED(ERR_LED), .ACT_LED(ACT_LED)
   );

   int          n_checks = 0;
   int          n_fail = 0;
   int          rst_epoch = 0;
   int          frames = 0;
   logic        rts_q = 1'b0;
   logic [7:0]  exp_q[$];

   // reference model state
   logic [15:0] m_in;
   logic [8:0]  m_sel;
   logic        m_err, m_act;

   always @(posedge CLK) rts_q <= RTS;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_outputs(input string tag);
      chk({tag, "/prj_in"},  32'(PRJ_IN),  32'(m_in));
      chk({tag, "/prj_sel"}, 32'(PRJ_SEL), 32'(m_sel));
      chk({tag, "/err_led"}, 32'(ERR_LED), 32'(m_err));
      chk({tag, "/act_led"}, 32'(ACT_LED), 32'(m_act));
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop_bit);
      @(negedge CLK);
      RX = 1'b0;
      repeat (DIV) @(negedge CLK);
      for (int i = 0; i < 8; i++) begin
         RX = b[i];
         repeat (DIV) @(negedge CLK);
      end
      RX = stop_bit;
      repeat (DIV) @(negedge CLK);
      RX = 1'b1;
      if (!stop_bit) repeat (3 * DIV) @(negedge CLK);
      repeat (2) @(negedge CLK);
   endtask

   task automatic cmd_set_in(input int lane, input logic [7:0] data);
      send_byte({2'b00, 6'(lane)}, 1'b1);
      send_byte(data, 1'b1);
      if (lane < 2) m_in[8*lane +: 8] = data;
      m_act = ~m_act;
      check_outputs("set_in");
   endtask

   task automatic cmd_set_sel(input logic [5:0] hi, input logic [7:0] lo);
      logic [13:0] full;
      send_byte({2'b01, hi}, 1'b1);
      send_byte(lo, 1'b1);
      full  = {hi, lo};
      m_sel = full[8:0];
      m_act = ~m_act;
      check_outputs("set_sel");
   endtask

   task automatic cmd_read();
      logic [15:0] snap;
      snap = PRJ_OUT;
      send_byte({2'b10, 6'($urandom)}, 1'b1);
      if (exp_q.size() + 2 <= 4) begin
         exp_q.push_back(snap[7:0]);
         exp_q.push_back(snap[15:8]);
      end else begin
         m_err = 1'b1;
      end
      m_act = ~m_act;
      check_outputs("read");
   endtask

   task automatic cmd_status();
      logic [7:0] st;
      st = {PRJ_READY, RTS, m_err, 5'b0};
      send_byte({2'b11, 6'($urandom)}, 1'b1);
      exp_q.push_back(st);
      m_act = ~m_act;
      check_outputs("status");
   endtask

   task automatic wait_drain(input int budget);
      int n = 0;
      while (exp_q.size() != 0 && n < budget) begin
         @(negedge CLK);
         n++;
      end
      chk("drain", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
      repeat (2 * DIV) @(negedge CLK);
   endtask

   task automatic do_reset();
      @(negedge CLK);
      RESET_N = 1'b0;
      rst_epoch++;
      exp_q.delete();
      m_in = '0; m_sel = '0; m_err = 1'b0; m_act = 1'b0;
      @(negedge CLK);
      chk("reset/tx", 32'(TX), 32'd1);
      check_outputs("reset");
      RESET_N = 1'b1;
      repeat (2) @(negedge CLK);
   endtask

   // TX monitor: decode each frame at mid-bit, compare against the scoreboard queue
   initial begin
      forever begin
         @(negedge CLK);
         if (RESET_N === 1'b1 && TX === 1'b0) begin : frame
            int         ep;
            logic [7:0] b;
            logic       stp;
            ep = rst_epoch;
            chk("tx_rts_gate", 32'(rts_q), 32'd0);
            repeat (DIV / 2 - 1) @(negedge CLK);
            for (int i = 0; i < 8; i++) begin
               repeat (DIV) @(negedge CLK);
               b[i] = TX;
            end
            repeat (DIV) @(negedge CLK);
            stp = TX;
            if (ep == rst_epoch) begin
               frames++;
               chk("tx_stop_bit", 32'(stp), 32'd1);
               if (exp_q.size() == 0) begin
                  n_checks++;
                  n_fail++;
                  $display("FAIL tx_unexpected: got frame 0x%0h, expected no frame", b);
               end else begin
                  chk("tx_byte", 32'(b), 32'(exp_q.pop_front()));
               end
            end
         end
      end
   end

   initial begin
      #900_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int f0;
      m_in = '0; m_sel = '0; m_err = 1'b0; m_act = 1'b0;
      repeat (2) @(negedge CLK);
      do_reset();

      // 1: two lane writes
      cmd_set_in(1, 8'hA5);
      cmd_set_in(0, 8'h3C);
      chk("t1_prj_in", 32'(PRJ_IN), 32'h0000_A53C);

      // 2: select writes, truncated to 9 bits
      cmd_set_sel(6'h01, 8'h23);
      chk("t2_sel_123", 32'(PRJ_SEL), 32'h123);
      cmd_set_sel(6'h3F, 8'hFF);
      chk("t2_sel_1ff", 32'(PRJ_SEL), 32'h1FF);

      // 3: READ, then READ held off by RTS
      PRJ_OUT = 16'hBEEF;
      cmd_read();
      wait_drain(600);
      RTS = 1'b1;
      PRJ_OUT = 16'h5AC3;
      cmd_read();
      repeat (300) @(negedge CLK);
      chk("t3_held_count", 32'(exp_q.size()), 32'd2);
      chk("t3_tx_idle", 32'(TX), 32'd1);
      RTS = 1'b0;
      wait_drain(600);

      // random command mix
      for (int k = 0; k < 16; k++) begin
         case ($urandom_range(0, 3))
            0: cmd_set_in(int'($urandom_range(0, 2)), 8'($urandom));
            1: cmd_set_sel(6'($urandom), 8'($urandom));
            2: begin
               PRJ_OUT = 16'($urandom);
               cmd_read();
               wait_drain(600);
            end
            default: begin
               PRJ_READY = 1'($urandom);
               cmd_status();
               wait_drain(400);
            end
         endcase
      end

      // 4: framing error, then a good command
      send_byte(8'h00, 1'b0);
      m_err = 1'b1;
      check_outputs("t4_ferr");
      cmd_set_in(0, 8'h11);
      chk("t4_lane0", 32'(PRJ_IN[7:0]), 32'h11);
      PRJ_READY = 1'b1;
      cmd_status();
      wait_drain(400);

      // 5: queue overflow drops the whole third response
      do_reset();
      RTS = 1'b1;
      PRJ_OUT = 16'h1234;
      cmd_read();
      cmd_read();
      chk("t5_no_err_yet", 32'(ERR_LED), 32'd0);
      PRJ_OUT = 16'h9876;
      cmd_read();
      chk("t5_err_set", 32'(ERR_LED), 32'd1);
      f0 = frames;
      RTS = 1'b0;
      wait_drain(1500);
      repeat (300) @(negedge CLK);
      chk("t5_frame_count", 32'(frames - f0), 32'd4);

      // 6: out-of-range lane, then reset in the middle of a TX frame
      cmd_set_in(5, 8'h77);
      PRJ_OUT = 16'hC0DE;
      cmd_read();
      n = 0;
      while (TX !== 1'b0 && n < 300) begin
         @(negedge CLK);
         n++;
      end
      chk("t6_frame_started", 32'(TX), 32'd0);
      repeat (30) @(negedge CLK);
      do_reset();
      repeat (300) @(negedge CLK);
      chk("t6_tx_idle_after", 32'(TX), 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
